// File: rtl/lcd_layer_compositor.sv
// LCD timing generator with N-layer colour-keyed overlay compositor.
// Config is shadowed at frame start; output RGB/HD/VD lag requests by LAYER_LAT+1.
module lcd_layer_compositor #(
    parameter int H_ACTIVE  = 800,
    parameter int H_BLANK   = 46,
    parameter int H_FRONT   = 210,
    parameter int V_ACTIVE  = 480,
    parameter int V_BLANK   = 23,
    parameter int V_FRONT   = 22,
    parameter int N_LAYER   = 4,
    parameter int CW        = 8,
    parameter int LAYER_LAT = 1
) (
    input  logic                      iCLK,
    input  logic                      iRST_n,
    input  logic                      iEnable,
    input  logic                      iTest_mode,
    input  logic [3*CW-1:0]           iBG_RGB,
    input  logic [N_LAYER-1:0]        iLayer_en,
    input  logic [N_LAYER*3*CW-1:0]   iLayer_key,
    input  logic [N_LAYER*3*CW-1:0]   iLayer_RGB,
    output logic                      oReq_valid,
    output logic [10:0]               oReqX,
    output logic [9:0]                oReqY,
    output logic                      oNewFrame,
    output logic                      oEndFrame,
    output logic [15:0]               oFrame_cnt,
    output logic                      oHD,
    output logic                      oVD,
    output logic [CW-1:0]             oLCD_R,
    output logic [CW-1:0]             oLCD_G,
    output logic [CW-1:0]             oLCD_B
);

    localparam int PW     = 3 * CW;
    localparam int H_LINE = H_BLANK + H_ACTIVE + H_FRONT;
    localparam int V_LINE = V_BLANK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] X_LAST = 11'(H_LINE - 1);
    localparam logic [10:0] X_ACT0 = 11'(H_BLANK);
    localparam logic [10:0] X_ACT1 = 11'(H_BLANK + H_ACTIVE);
    localparam logic [10:0] X_END  = 11'(H_BLANK + H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_LINE - 1);
    localparam logic [9:0]  Y_ACT0 = 10'(V_BLANK);
    localparam logic [9:0]  Y_ACT1 = 10'(V_BLANK + V_ACTIVE);
    localparam logic [9:0]  Y_END  = 10'(V_BLANK + V_ACTIVE - 1);

    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 10'd1;
        end else begin
            x_cnt <= x_cnt + 11'd1;
        end
    end

    logic h_act;
    logic v_act;
    logic act;

    assign h_act      = (x_cnt >= X_ACT0) && (x_cnt < X_ACT1);
    assign v_act      = (y_cnt >= Y_ACT0) && (y_cnt < Y_ACT1);
    assign act        = h_act && v_act;
    assign oReq_valid = act;
    assign oReqX      = act ? x_cnt - X_ACT0 : '0;
    assign oReqY      = act ? y_cnt - Y_ACT0 : '0;
    assign oNewFrame  = (x_cnt == '0) && (y_cnt == '0);
    assign oEndFrame  = (x_cnt == X_END) && (y_cnt == Y_END);

    logic                    sh_enable;
    logic                    sh_test;
    logic [PW-1:0]           sh_bg;
    logic [N_LAYER-1:0]      sh_en;
    logic [N_LAYER*PW-1:0]   sh_key;

    // Config only changes at frame start so a frame never tears.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sh_enable  <= 1'b0;
            sh_test    <= 1'b0;
            sh_bg      <= '0;
            sh_en      <= '0;
            sh_key     <= '0;
            oFrame_cnt <= '0;
        end else if (oNewFrame) begin
            sh_enable  <= iEnable;
            sh_test    <= iTest_mode;
            sh_bg      <= iBG_RGB;
            sh_en      <= iLayer_en;
            sh_key     <= iLayer_key;
            oFrame_cnt <= oFrame_cnt + 16'd1;
        end
    end

    logic [13:0] tap_in;
    logic [13:0] tap_c;

    assign tap_in = {act, x_cnt != '0, y_cnt != '0, oReqX};

    generate
        if (LAYER_LAT == 0) begin : g_nolat
            assign tap_c = tap_in;
        end else begin : g_lat
            logic [13:0] pipe [LAYER_LAT];

            always_ff @(posedge iCLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    for (int i = 0; i < LAYER_LAT; i++)
                        pipe[i] <= '0;
                end else begin
                    pipe[0] <= tap_in;
                    for (int i = 1; i < LAYER_LAT; i++)
                        pipe[i] <= pipe[i-1];
                end
            end

            assign tap_c = pipe[LAYER_LAT-1];
        end
    endgenerate

    logic        act_c;
    logic        hd_c;
    logic        vd_c;
    logic [10:0] x_c;

    assign act_c = tap_c[13];
    assign hd_c  = tap_c[12];
    assign vd_c  = tap_c[11];
    assign x_c   = tap_c[10:0];

    logic [13:0]   bar_num;
    logic [2:0]    bar;
    logic [PW-1:0] bar_pix;

    assign bar_num = {x_c, 3'b000};
    assign bar     = 3'(bar_num / 14'(H_ACTIVE));
    assign bar_pix = {{CW{~bar[2]}}, {CW{~bar[1]}}, {CW{~bar[0]}}};

    logic [PW-1:0] layer_pix;

    // Ascending scan: the highest opaque enabled layer wins.
    always_comb begin
        layer_pix = sh_bg;
        for (int k = 0; k < N_LAYER; k++) begin
            if (sh_en[k] && (iLayer_RGB[k*PW +: PW] != sh_key[k*PW +: PW]))
                layer_pix = iLayer_RGB[k*PW +: PW];
        end
    end

    logic [PW-1:0] pix_c;

    always_comb begin
        if (!act_c)
            pix_c = '0;
        else if (sh_test)
            pix_c = bar_pix;
        else if (!sh_enable)
            pix_c = sh_bg;
        else
            pix_c = layer_pix;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHD    <= 1'b0;
            oVD    <= 1'b0;
            oLCD_R <= '0;
            oLCD_G <= '0;
            oLCD_B <= '0;
        end else begin
            oHD    <= hd_c;
            oVD    <= vd_c;
            oLCD_R <= pix_c[3*CW-1:2*CW];
            oLCD_G <= pix_c[2*CW-1:CW];
            oLCD_B <= pix_c[CW-1:0];
        end
    end

endmodule

// File: tb/tb_lcd_layer_compositor.sv
// Randomised bench for lcd_layer_compositor on a shrunken raster,
// checked cycle by cycle against a frame-arithmetic reference model.
module tb_lcd_layer_compositor;

    localparam int HA  = 16;
    localparam int HB  = 4;
    localparam int HF  = 5;
    localparam int VA  = 6;
    localparam int VB  = 2;
    localparam int VF  = 2;
    localparam int NL  = 4;
    localparam int CW  = 8;
    localparam int LAT = 1;
    localparam int PW  = 3 * CW;
    localparam int HL  = HA + HB + HF;
    localparam int VL  = VA + VB + VF;
    localparam int FL  = HL * VL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              iRST_n;
    logic              iEnable;
    logic              iTest_mode;
    logic [PW-1:0]     iBG_RGB;
    logic [NL-1:0]     iLayer_en;
    logic [NL*PW-1:0]  iLayer_key;
    logic [NL*PW-1:0]  iLayer_RGB;
    logic              oReq_valid;
    logic [10:0]       oReqX;
    logic [9:0]        oReqY;
    logic              oNewFrame;
    logic              oEndFrame;
    logic [15:0]       oFrame_cnt;
    logic              oHD;
    logic              oVD;
    logic [CW-1:0]     oLCD_R;
    logic [CW-1:0]     oLCD_G;
    logic [CW-1:0]     oLCD_B;

    lcd_layer_compositor #(
        .H_ACTIVE(HA), .H_BLANK(HB), .H_FRONT(HF),
        .V_ACTIVE(VA), .V_BLANK(VB), .V_FRONT(VF),
        .N_LAYER(NL), .CW(CW), .LAYER_LAT(LAT)
    ) dut (
        .iCLK(clk),
        .iRST_n(iRST_n),
        .iEnable(iEnable),
        .iTest_mode(iTest_mode),
        .iBG_RGB(iBG_RGB),
        .iLayer_en(iLayer_en),
        .iLayer_key(iLayer_key),
        .iLayer_RGB(iLayer_RGB),
        .oReq_valid(oReq_valid),
        .oReqX(oReqX),
        .oReqY(oReqY),
        .oNewFrame(oNewFrame),
        .oEndFrame(oEndFrame),
        .oFrame_cnt(oFrame_cnt),
        .oHD(oHD),
        .oVD(oVD),
        .oLCD_R(oLCD_R),
        .oLCD_G(oLCD_G),
        .oLCD_B(oLCD_B)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
    endtask

    // Reference state: time since reset release plus frame-latched config.
    int                t;
    bit                in_rst;
    bit                m_test;
    bit                m_enable;
    logic [PW-1:0]     m_bg;
    logic [NL-1:0]     m_len;
    logic [NL*PW-1:0]  m_key;
    logic [15:0]       m_fcnt;
    logic [PW+1:0]     m_out;

    function automatic void pos(input int tt, output int x, output int y);
        int p;
        p = tt % FL;
        x = p % HL;
        y = p / HL;
    endfunction

    function automatic logic [PW-1:0] ref_pix(input bit a, input int x,
                                              input logic [NL*PW-1:0] rgb);
        int bar;
        if (!a)
            return '0;
        if (m_test) begin
            bar = x * 8 / HA;
            return {((bar & 4) != 0) ? 8'h00 : 8'hFF,
                    ((bar & 2) != 0) ? 8'h00 : 8'hFF,
                    ((bar & 1) != 0) ? 8'h00 : 8'hFF};
        end
        if (!m_enable)
            return m_bg;
        for (int k = NL - 1; k >= 0; k--)
            if (m_len[k] && rgb[k*PW +: PW] != m_key[k*PW +: PW])
                return rgb[k*PW +: PW];
        return m_bg;
    endfunction

    task automatic step();
        int x, y, xc, yc;
        bit a, ac, hdc, vdc, nf, ef;
        logic [PW-1:0] pix;
        if (in_rst) begin
            x = 0;
            y = 0;
        end else begin
            pos(t, x, y);
        end
        a  = x >= HB && x < HB + HA && y >= VB && y < VB + VA;
        nf = x == 0 && y == 0;
        ef = x == HB + HA - 1 && y == VB + VA - 1;
        chk("req", {oReq_valid, oReqX, oReqY, oNewFrame, oEndFrame},
            {a, a ? 11'(x - HB) : 11'd0, a ? 10'(y - VB) : 10'd0, nf, ef});
        if (in_rst || t < LAT) begin
            ac = 0; hdc = 0; vdc = 0; xc = 0;
        end else begin
            pos(t - LAT, xc, yc);
            ac  = xc >= HB && xc < HB + HA && yc >= VB && yc < VB + VA;
            hdc = xc != 0;
            vdc = yc != 0;
        end
        pix = ref_pix(ac, xc - HB, iLayer_RGB);
        @(posedge clk);
        if (!in_rst) begin
            m_out = {hdc, vdc, pix};
            if (nf) begin
                m_test   = iTest_mode;
                m_enable = iEnable;
                m_bg     = iBG_RGB;
                m_len    = iLayer_en;
                m_key    = iLayer_key;
                m_fcnt   = m_fcnt + 16'd1;
            end
            t++;
        end
        @(negedge clk);
        chk("pix", {oHD, oVD, oLCD_R, oLCD_G, oLCD_B}, m_out);
        chk("fcnt", oFrame_cnt, m_fcnt);
    endtask

    task automatic step_to(input int px, input int py);
        while ((t % FL) != py * HL + px)
            step();
    endtask

    task automatic show(input int px, input int py, input string tag,
                        input logic [PW-1:0] exp);
        step_to(px, py);
        repeat (LAT + 1) step();
        chk(tag, {oLCD_R, oLCD_G, oLCD_B}, exp);
    endtask

    task automatic drive_rand();
        if ($urandom_range(7, 0) == 0) begin
            iEnable    = $urandom_range(3, 0) != 0;
            iTest_mode = $urandom_range(3, 0) == 0;
            iBG_RGB    = 24'($urandom);
            iLayer_en  = 4'($urandom);
            for (int k = 0; k < NL; k++)
                iLayer_key[k*PW +: PW] = 24'($urandom_range(3, 0));
        end
        for (int k = 0; k < NL; k++)
            iLayer_RGB[k*PW +: PW] = $urandom_range(1, 0) != 0
                ? m_key[k*PW +: PW] : 24'($urandom);
    endtask

    task automatic model_reset();
        in_rst   = 1;
        t        = 0;
        m_test   = 0;
        m_enable = 0;
        m_bg     = '0;
        m_len    = '0;
        m_key    = '0;
        m_fcnt   = '0;
        m_out    = '0;
    endtask

    initial begin
        iRST_n     = 1'b0;
        iEnable    = 1'b0;
        iTest_mode = 1'b0;
        iBG_RGB    = '0;
        iLayer_en  = '0;
        iLayer_key = '0;
        iLayer_RGB = '0;
        model_reset();
        #2;
        chk("rst_out", {oHD, oVD, oLCD_R, oLCD_G, oLCD_B}, 26'd0);
        repeat (3) step();
        iRST_n = 1'b1;
        in_rst = 0;

        repeat (4 * FL) begin
            drive_rand();
            step();
        end

        // Layer 2 keyed out, then opaque.
        iEnable    = 1'b1;
        iTest_mode = 1'b0;
        iBG_RGB    = 24'h102030;
        iLayer_en  = 4'b0101;
        iLayer_key = {24'h0, 24'hFF00FF, 24'h0, 24'h000000};
        iLayer_RGB = {24'h0, 24'hFF00FF, 24'h0, 24'h00FF00};
        step_to(0, 0);
        step();
        show(HB + 3, VB + 1, "l2_keyed", 24'h00FF00);
        iLayer_RGB[2*PW +: PW] = 24'h123456;
        show(HB + 5, VB + 2, "l2_opaque", 24'h123456);

        // Mid-frame BG change must wait for the next frame.
        iLayer_RGB = {24'h0, 24'hFF00FF, 24'h0, 24'h000000};
        iBG_RGB    = 24'hABCDEF;
        show(HB + 2, VB + 4, "bg_hold", 24'h102030);
        show(HB + 2, VB + 1, "bg_next", 24'hABCDEF);

        iTest_mode = 1'b1;
        step_to(0, 0);
        step();
        show(HB + 0,  VB + 1, "bar0", 24'hFFFFFF);
        show(HB + 4,  VB + 1, "bar2", 24'hFF00FF);
        show(HB + 6,  VB + 1, "bar3", 24'hFF0000);
        show(HB + 15, VB + 1, "bar7", 24'h000000);
        show(1, VB + 2, "blank", 24'h000000);

        // Asynchronous reset mid-line.
        iTest_mode = 1'b0;
        step_to(HB + 6, VB + 3);
        iRST_n = 1'b0;
        #1;
        chk("async_rst", {oHD, oVD, oLCD_R, oLCD_G, oLCD_B}, 26'd0);
        chk("async_fcnt", oFrame_cnt, 16'd0);
        model_reset();
        repeat (3) step();
        iRST_n = 1'b1;
        in_rst = 0;
        step();
        chk("fcnt_after_rst", oFrame_cnt, 16'd1);

        repeat (3 * FL) begin
            drive_rand();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
